// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if;
    logic        in_valid;
    logic [1:0]  in_mask;
    logic [31:0] in_pc;
    logic [63:0] in_inst;
    logic        in_ready;

    logic [1:0]  out_valid;
    logic [31:0] out_pc_0;
    logic [31:0] out_inst_0;
    logic [31:0] out_pc_1;
    logic [31:0] out_inst_1;
    logic [1:0]  out_pop;

    modport master (
        output in_valid, in_mask, in_pc, in_inst, out_pop,
        input  in_ready, out_valid, out_pc_0, out_inst_0, out_pc_1, out_inst_1
    );

    modport slave (
        input  in_valid, in_mask, in_pc, in_inst, out_pop,
        output in_ready, out_valid, out_pc_0, out_inst_0, out_pc_1, out_inst_1
    );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue between I-cache response and decode; flushed on redirect.
// Optional FETCH_QUEUE_STATS_EN adds saturating full/empty cycle counters.
module fetch_queue #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    fetch_queue_if.slave      fq,
    output logic [PTR_BITS:0] count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]       stat_full_cycles,
    output logic [31:0]       stat_empty_cycles
`endif
);

    // in_ready only looks at registered occupancy so it never depends on out_pop.
    localparam logic [PTR_BITS:0] READY_LIMIT = (PTR_BITS+1)'(DEPTH - 2);

    logic [31:0]         pc_mem   [DEPTH];
    logic [31:0]         inst_mem [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr_nx1;
    logic [PTR_BITS-1:0] wr_ptr_nx1;
    logic                push;
    logic [1:0]          push_n;
    logic [1:0]          pop_n;

    assign fq.in_ready = (count <= READY_LIMIT);
    assign push        = fq.in_valid & fq.in_ready & ~flush;
    assign push_n      = push ? ({1'b0, fq.in_mask[0]} + {1'b0, fq.in_mask[1]}) : 2'd0;
    assign pop_n       = fq.out_pop;
    assign rd_ptr_nx1  = rd_ptr + PTR_BITS'(1);
    assign wr_ptr_nx1  = wr_ptr + PTR_BITS'(1);

    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            pc_mem[wr_ptr]   <= fq.in_pc;
            inst_mem[wr_ptr] <= fq.in_inst[31:0];
        end
        if (push_n == 2'd2) begin
            pc_mem[wr_ptr_nx1]   <= fq.in_pc + 32'd4;
            inst_mem[wr_ptr_nx1] <= fq.in_inst[63:32];
        end
    end

    // Flush has the same effect as reset on the pointers; pops and pushes that cycle are dropped.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_BITS'(pop_n);
            wr_ptr <= wr_ptr + PTR_BITS'(push_n);
            count  <= count + (PTR_BITS+1)'(push_n) - (PTR_BITS+1)'(pop_n);
        end
    end

    assign fq.out_valid  = {(count >= (PTR_BITS+1)'(2)), (count != '0)};
    assign fq.out_pc_0   = pc_mem[rd_ptr];
    assign fq.out_inst_0 = inst_mem[rd_ptr];
    assign fq.out_pc_1   = pc_mem[rd_ptr_nx1];
    assign fq.out_inst_1 = inst_mem[rd_ptr_nx1];

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_full_cycles  <= '0;
            stat_empty_cycles <= '0;
        end else begin
            if (fq.in_valid && !fq.in_ready && stat_full_cycles != 32'hFFFF_FFFF)
                stat_full_cycles <= stat_full_cycles + 32'd1;
            if (count == '0 && !flush && stat_empty_cycles != 32'hFFFF_FFFF)
                stat_empty_cycles <= stat_empty_cycles + 32'd1;
        end
    end
`endif

    // Decode may never pop more than it was shown; 2'b10 is not a legal fetch mask.
    assert property (@(posedge clk) disable iff (reset)
        (fq.out_pop != 2'b11) && ((PTR_BITS+1)'(fq.out_pop) <= count));
    assert property (@(posedge clk) disable iff (reset)
        !(fq.in_valid && fq.in_mask == 2'b10));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [4:0] count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_empty_cycles;
`endif

    fetch_queue_if fq_if ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .fq    (fq_if),
        .count (count)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_full_cycles  (stat_full_cycles),
        .stat_empty_cycles (stat_empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference: entries are {pc, inst}, oldest at index 0.
    logic [63:0] mq [$];

    task automatic idle_inputs();
        fq_if.in_valid = 1'b0;
        fq_if.in_mask  = 2'b00;
        fq_if.in_pc    = '0;
        fq_if.in_inst  = '0;
        fq_if.out_pop  = 2'b00;
        flush          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
    endtask

    // One clock of stimulus; model applies the same rules the queue is specified with.
    task automatic step(input logic v, input logic [1:0] m, input logic [31:0] pc,
                        input logic [63:0] inst, input logic [1:0] pop, input logic fl);
        bit rdy;
        fq_if.in_valid = v;
        fq_if.in_mask  = m;
        fq_if.in_pc    = pc;
        fq_if.in_inst  = inst;
        fq_if.out_pop  = pop;
        flush          = fl;
        rdy = (DEPTH - mq.size()) >= 2;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < int'(pop); i++) void'(mq.pop_front());
            if (v && rdy) begin
                if (m[0]) mq.push_back({pc, inst[31:0]});
                if (m[1]) mq.push_back({pc + 32'd4, inst[63:32]});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (fq_if.out_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_out_valid got=%b exp=00", fq_if.out_valid);
        end
        tests_run++;
        if (fq_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready got=%b exp=1", fq_if.in_ready);
        end
        tests_run++;
        if (count !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
    endtask

    task automatic test_first_pair();
        do_reset();
        step(1'b1, 2'b11, 32'hBFC0_0000, {32'h2, 32'h1}, 2'd0, 1'b0);
        tests_run++;
        if (fq_if.out_valid !== 2'b11 || fq_if.out_pc_0 !== 32'hBFC0_0000 || fq_if.out_inst_0 !== 32'h1 ||
            fq_if.out_pc_1 !== 32'hBFC0_0004 || fq_if.out_inst_1 !== 32'h2 || count !== 5'd2) begin
            tests_failed++;
            $display("FAIL first_pair got v=%b pc0=%h i0=%h pc1=%h i1=%h cnt=%0d exp v=11 pc0=bfc00000 i0=1 pc1=bfc00004 i1=2 cnt=2",
                     fq_if.out_valid, fq_if.out_pc_0, fq_if.out_inst_0, fq_if.out_pc_1, fq_if.out_inst_1, count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b11, 32'h1000 + 32'(8 * i), {32'(2 * i + 1), 32'(2 * i)}, 2'd0, 1'b0);
        tests_run++;
        if (count !== 5'd16 || fq_if.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_fill got cnt=%0d rdy=%b exp cnt=16 rdy=0", count, fq_if.in_ready);
        end
        step(1'b1, 2'b11, 32'h9000, {32'hDEAD, 32'hBEEF}, 2'd0, 1'b0);
        tests_run++;
        if (count !== 5'd16 || fq_if.out_pc_0 !== 32'h1000 || fq_if.out_inst_0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL full_drop got cnt=%0d pc0=%h i0=%h exp cnt=16 pc0=00001000 i0=0",
                     count, fq_if.out_pc_0, fq_if.out_inst_0);
        end
        // Drain everything and confirm the dropped pair never surfaced.
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (fq_if.out_pc_0 !== 32'h1000 + 32'(8 * i) || fq_if.out_inst_1 !== 32'(2 * i + 1)) begin
                tests_failed++;
                $display("FAIL full_drain[%0d] got pc0=%h i1=%h exp pc0=%h i1=%h", i,
                         fq_if.out_pc_0, fq_if.out_inst_1, 32'h1000 + 32'(8 * i), 32'(2 * i + 1));
            end
            step(1'b0, 2'b00, '0, '0, 2'd2, 1'b0);
        end
        tests_run++;
        if (count !== 5'd0 || fq_if.out_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL full_empty got cnt=%0d v=%b exp cnt=0 v=00", count, fq_if.out_valid);
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        step(1'b1, 2'b01, 32'h2000, {32'h0, 32'hA0}, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b1, 2'b11, 32'h2004 + 32'(8 * i), {32'h0, 32'h0}, 2'd0, 1'b0);
        tests_run++;
        if (count !== 5'd15 || fq_if.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL almost_full got cnt=%0d rdy=%b exp cnt=15 rdy=0", count, fq_if.in_ready);
        end
        step(1'b0, 2'b00, '0, '0, 2'd1, 1'b0);
        tests_run++;
        if (count !== 5'd14 || fq_if.in_ready !== 1'b1 || fq_if.out_pc_0 !== 32'h2004) begin
            tests_failed++;
            $display("FAIL almost_full_pop got cnt=%0d rdy=%b pc0=%h exp cnt=14 rdy=1 pc0=00002004",
                     count, fq_if.in_ready, fq_if.out_pc_0);
        end
    endtask

    task automatic test_steady();
        logic [31:0] base;
        logic [31:0] pc;
        do_reset();
        base = 32'h0040_0000;
        step(1'b1, 2'b11, base, {~(base + 32'd4), ~base}, 2'd0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            pc = base + 32'(8 * i);
            step(1'b1, 2'b11, pc, {~(pc + 32'd4), ~pc}, 2'd2, 1'b0);
            tests_run++;
            if (fq_if.out_pc_0 !== pc || fq_if.out_pc_1 !== pc + 32'd4 || fq_if.out_inst_0 !== ~pc ||
                fq_if.out_inst_1 !== ~(pc + 32'd4) || count !== 5'd2 || fq_if.out_valid !== 2'b11) begin
                tests_failed++;
                $display("FAIL steady[%0d] got pc0=%h pc1=%h i0=%h i1=%h cnt=%0d exp pc0=%h pc1=%h cnt=2",
                         i, fq_if.out_pc_0, fq_if.out_pc_1, fq_if.out_inst_0, fq_if.out_inst_1,
                         count, pc, pc + 32'd4);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'b11, 32'h3000 + 32'(8 * i), {32'h11, 32'h10}, 2'd0, 1'b0);
        step(1'b1, 2'b11, 32'h7000, {32'h77, 32'h70}, 2'd2, 1'b1);
        tests_run++;
        if (count !== 5'd0 || fq_if.out_valid !== 2'b00 || fq_if.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush got cnt=%0d v=%b rdy=%b exp cnt=0 v=00 rdy=1",
                     count, fq_if.out_valid, fq_if.in_ready);
        end
        step(1'b1, 2'b01, 32'h8000, {32'h0, 32'h80}, 2'd0, 1'b0);
        tests_run++;
        if (count !== 5'd1 || fq_if.out_valid !== 2'b01 || fq_if.out_pc_0 !== 32'h8000 ||
            fq_if.out_inst_0 !== 32'h80) begin
            tests_failed++;
            $display("FAIL flush_after got cnt=%0d v=%b pc0=%h i0=%h exp cnt=1 v=01 pc0=00008000 i0=80",
                     count, fq_if.out_valid, fq_if.out_pc_0, fq_if.out_inst_0);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [1:0]  m;
        logic [1:0]  pop;
        logic        fl;
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  exp_v;
        int          sz;
        int          errs;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            sz   = mq.size();
            v    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       m = 2'b00;
                1:       m = 2'b01;
                default: m = 2'b11;
            endcase
            pop  = 2'($urandom_range(0, (sz < 2) ? sz : 2));
            fl   = ($urandom_range(0, 39) == 0);
            pc   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            inst = {$urandom(), $urandom()};
            step(v, m, pc, inst, pop, fl);
            sz    = mq.size();
            exp_v = {(sz >= 2), (sz >= 1)};
            errs  = 0;
            tests_run++;
            if (count !== 5'(sz) || fq_if.in_ready !== ((DEPTH - sz) >= 2) || fq_if.out_valid !== exp_v)
                errs++;
            if (sz >= 1 && {fq_if.out_pc_0, fq_if.out_inst_0} !== mq[0]) errs++;
            if (sz >= 2 && {fq_if.out_pc_1, fq_if.out_inst_1} !== mq[1]) errs++;
            if (errs != 0) begin
                tests_failed++;
                $display("FAIL random[%0d] got cnt=%0d rdy=%b v=%b pc0=%h pc1=%h exp cnt=%0d v=%b pc0=%h pc1=%h",
                         c, count, fq_if.in_ready, fq_if.out_valid, fq_if.out_pc_0, fq_if.out_pc_1, sz, exp_v,
                         (sz >= 1) ? mq[0][63:32] : 32'h0, (sz >= 2) ? mq[1][63:32] : 32'h0);
            end
        end
    endtask

`ifdef FETCH_QUEUE_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, '0, '0, 2'd0, 1'b0);
        tests_run++;
        if (stat_empty_cycles !== 32'd3 || stat_full_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL stats_empty got empty=%0d full=%0d exp empty=3 full=0",
                     stat_empty_cycles, stat_full_cycles);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 2'b11, 32'(8 * i), '0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 32'h100, '0, 2'd0, 1'b0);
        tests_run++;
        if (stat_full_cycles !== 32'd5) begin
            tests_failed++;
            $display("FAIL stats_full got=%0d exp=5", stat_full_cycles);
        end
        step(1'b0, 2'b00, '0, '0, 2'd0, 1'b1);
        tests_run++;
        if (stat_full_cycles !== 32'd5) begin
            tests_failed++;
            $display("FAIL stats_flush got=%0d exp=5", stat_full_cycles);
        end
        do_reset();
        tests_run++;
        if (stat_full_cycles !== 32'd0 || stat_empty_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL stats_reset got full=%0d empty=%0d exp 0 0", stat_full_cycles, stat_empty_cycles);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_first_pair();
        test_full();
        test_almost_full();
        test_steady();
        test_flush();
        test_random();
`ifdef FETCH_QUEUE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
